// File: rtl/ucie_ctl_tx_fifo.sv
// Single-clock show-ahead TX data FIFO between the FDI and RDI sides of the UCIe controller.
// Optional almost-full output is enabled with UCIE_CTL_TX_FIFO_AFULL_EN.
module ucie_ctl_tx_fifo #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrst_n,
    input  logic                  rrst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   o_fifo_count,
    output logic                  o_wr_drop_err,
    output logic                  o_rd_underflow_err
`ifdef UCIE_CTL_TX_FIFO_AFULL_EN
    ,
    output logic                  o_almost_full
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  flush;
    logic                  do_wr;
    logic                  do_rd;

    assign flush = ~wrst_n | ~rrst_n;
    assign do_wr = winc & ~wfull;
    assign do_rd = rinc & ~rempty;

    // Status is derived only from the registered pointers, never from the strobes.
    assign rempty       = (wptr == rptr);
    assign wfull        = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                          (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign o_fifo_count = wptr - rptr;
    assign rdata        = mem[rptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr               <= '0;
            rptr               <= '0;
            o_wr_drop_err      <= 1'b0;
            o_rd_underflow_err <= 1'b0;
        end else if (flush) begin
            wptr               <= '0;
            rptr               <= '0;
            o_wr_drop_err      <= 1'b0;
            o_rd_underflow_err <= 1'b0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            if (winc && wfull) begin
                o_wr_drop_err <= 1'b1;
            end
            if (rinc && rempty) begin
                o_rd_underflow_err <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

`ifdef UCIE_CTL_TX_FIFO_AFULL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

    assign o_almost_full = (o_fifo_count >= AFULL_LVL);
`else
    logic unused_afull_thresh;

    assign unused_afull_thresh = (AFULL_THRESH != 0);
`endif

endmodule

// File: tb/tb_ucie_ctl_tx_fifo.sv
// Randomized self-checking bench for ucie_ctl_tx_fifo against a queue model.
// Covers almost-full only when UCIE_CTL_TX_FIFO_AFULL_EN is defined.
module tb_ucie_ctl_tx_fifo;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrst_n;
    logic          rrst_n;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          wfull;
    logic          rempty;
    logic [AW:0]   o_fifo_count;
    logic          o_wr_drop_err;
    logic          o_rd_underflow_err;
`ifdef UCIE_CTL_TX_FIFO_AFULL_EN
    logic          o_almost_full;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    bit            m_drop;
    bit            m_und;

    ucie_ctl_tx_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_THRESH(12)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wrst_n            (wrst_n),
        .rrst_n            (rrst_n),
        .winc              (winc),
        .wdata             (wdata),
        .rinc              (rinc),
        .rdata             (rdata),
        .wfull             (wfull),
        .rempty            (rempty),
        .o_fifo_count      (o_fifo_count),
        .o_wr_drop_err     (o_wr_drop_err),
        .o_rd_underflow_err(o_rd_underflow_err)
`ifdef UCIE_CTL_TX_FIFO_AFULL_EN
        ,
        .o_almost_full     (o_almost_full)
`endif
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d,
                       input bit fl);
        bit full;
        bit empty;
        full   = (q.size() == DEPTH);
        empty  = (q.size() == 0);
        winc   = w;
        rinc   = r;
        wdata  = d;
        wrst_n = !fl;
        rrst_n = !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_drop = 0;
            m_und  = 0;
        end else begin
            if (r) begin
                if (empty) m_und = 1;
                else void'(q.pop_front());
            end
            if (w) begin
                if (full) m_drop = 1;
                else q.push_back(d);
            end
        end
        #1;
        winc   = 1'b0;
        rinc   = 1'b0;
        wrst_n = 1'b1;
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_drop = 0;
        m_und  = 0;
        total++;
        if (rempty !== 1'b1 || wfull !== 1'b0 || o_fifo_count !== 0) begin
            bad++;
            $display("FAIL reset_init: empty=%b full=%b cnt=%0d want 1 0 0",
                     rempty, wfull, o_fifo_count);
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 64'(i + 100), 0);
        total++;
        if (int'(o_fifo_count) !== 5) begin
            bad++;
            $display("FAIL reset_pre_cnt: got %0d want 5", o_fifo_count);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if (rempty !== 1'b1 || wfull !== 1'b0 || o_fifo_count !== 0 ||
            o_wr_drop_err !== 1'b0 || o_rd_underflow_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: e=%b f=%b c=%0d d=%b u=%b want 1 0 0 0 0",
                     rempty, wfull, o_fifo_count, o_wr_drop_err,
                     o_rd_underflow_err);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_drop = 0;
        m_und  = 0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 64'(i), 0);
        total++;
        if (wfull !== 1'b1 || int'(o_fifo_count) !== 16) begin
            bad++;
            $display("FAIL fill_full: full=%b cnt=%0d want 1 16",
                     wfull, o_fifo_count);
        end
        cyc(1, 0, 64'hdead, 0);
        total++;
        if (o_wr_drop_err !== 1'b1 || int'(o_fifo_count) !== 16) begin
            bad++;
            $display("FAIL fill_drop: drop=%b cnt=%0d want 1 16",
                     o_wr_drop_err, o_fifo_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (rempty !== 1'b0 || rdata !== 64'(i)) begin
                bad++;
                $display("FAIL drain_data: empty=%b got %0h want %0h",
                         rempty, rdata, i);
            end
            cyc(0, 1, '0, 0);
        end
        total++;
        if (rempty !== 1'b1 || o_fifo_count !== 0) begin
            bad++;
            $display("FAIL drain_empty: empty=%b cnt=%0d want 1 0",
                     rempty, o_fifo_count);
        end
        cyc(0, 0, '0, 1);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] v;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                v = {$urandom, $urandom};
                cyc(1, 0, v, 0);
            end
            for (int i = 0; i < 10; i++) begin
                total++;
                if (rdata !== q[0]) begin
                    bad++;
                    $display("FAIL wrap_data: round %0d got %0h want %0h",
                             r, rdata, q[0]);
                end
                cyc(0, 1, '0, 0);
            end
        end
        total++;
        if (o_fifo_count !== 0 || rempty !== 1'b1) begin
            bad++;
            $display("FAIL wrap_cnt: cnt=%0d empty=%b want 0 1",
                     o_fifo_count, rempty);
        end
    endtask

    task automatic test_simultaneous();
        cyc(0, 0, '0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 64'(i + 7), 0);
        cyc(1, 1, 64'h55, 0);
        total++;
        if (int'(o_fifo_count) !== 15 || o_wr_drop_err !== 1'b1 ||
            rdata !== 64'd8) begin
            bad++;
            $display("FAIL sim_full: cnt=%0d drop=%b rd=%0h want 15 1 8",
                     o_fifo_count, o_wr_drop_err, rdata);
        end
        cyc(0, 0, '0, 1);
        cyc(1, 1, 64'h77, 0);
        total++;
        if (int'(o_fifo_count) !== 1 || o_rd_underflow_err !== 1'b1 ||
            rdata !== 64'h77) begin
            bad++;
            $display("FAIL sim_empty: cnt=%0d und=%b rd=%0h want 1 1 77",
                     o_fifo_count, o_rd_underflow_err, rdata);
        end
        cyc(0, 0, '0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 64'(i + 200), 0);
        cyc(1, 1, 64'h99, 0);
        total++;
        if (int'(o_fifo_count) !== 7 || rdata !== 64'd201 ||
            o_wr_drop_err !== 1'b0 || o_rd_underflow_err !== 1'b0) begin
            bad++;
            $display("FAIL sim_mid: cnt=%0d rd=%0h d=%b u=%b want 7 c9 0 0",
                     o_fifo_count, rdata, o_wr_drop_err, o_rd_underflow_err);
        end
    endtask

    task automatic test_flush();
        cyc(0, 0, '0, 1);
        cyc(0, 1, '0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 64'(i), 0);
        total++;
        if (o_rd_underflow_err !== 1'b1 || int'(o_fifo_count) !== 9) begin
            bad++;
            $display("FAIL flush_pre: und=%b cnt=%0d want 1 9",
                     o_rd_underflow_err, o_fifo_count);
        end
        cyc(1, 0, 64'h1234, 1);
        total++;
        if (o_fifo_count !== 0 || rempty !== 1'b1 ||
            o_wr_drop_err !== 1'b0 || o_rd_underflow_err !== 1'b0) begin
            bad++;
            $display("FAIL flush_post: cnt=%0d e=%b d=%b u=%b want 0 1 0 0",
                     o_fifo_count, rempty, o_wr_drop_err, o_rd_underflow_err);
        end
    endtask

    task automatic test_random();
        bit w;
        bit r;
        bit fl;
        for (int n = 0; n < 600; n++) begin
            w  = ($urandom_range(99) < ((n / 100) % 2 == 0 ? 70 : 35));
            r  = ($urandom_range(99) < ((n / 100) % 2 == 0 ? 35 : 70));
            fl = ($urandom_range(99) == 0);
            cyc(w, r, {$urandom, $urandom}, fl);
            total++;
            if (int'(o_fifo_count) !== q.size() ||
                rempty !== (q.size() == 0) ||
                wfull !== (q.size() == DEPTH) ||
                o_wr_drop_err !== m_drop ||
                o_rd_underflow_err !== m_und ||
                (q.size() != 0 && rdata !== q[0])) begin
                bad++;
                $display("FAIL rand_state: n=%0d cnt=%0d/%0d e=%b f=%b d=%b/%b u=%b/%b",
                         n, o_fifo_count, q.size(), rempty, wfull,
                         o_wr_drop_err, m_drop, o_rd_underflow_err, m_und);
            end
        end
    endtask

`ifdef UCIE_CTL_TX_FIFO_AFULL_EN
    task automatic test_afull();
        cyc(0, 0, '0, 1);
        for (int i = 0; i < 11; i++) cyc(1, 0, 64'(i), 0);
        total++;
        if (o_almost_full !== 1'b0) begin
            bad++;
            $display("FAIL afull_11: got %b want 0", o_almost_full);
        end
        cyc(1, 0, 64'd11, 0);
        total++;
        if (o_almost_full !== 1'b1) begin
            bad++;
            $display("FAIL afull_12: got %b want 1", o_almost_full);
        end
        cyc(0, 1, '0, 0);
        total++;
        if (o_almost_full !== 1'b0) begin
            bad++;
            $display("FAIL afull_fall: got %b want 0", o_almost_full);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        wrst_n = 1'b1;
        rrst_n = 1'b1;
        winc   = 1'b0;
        rinc   = 1'b0;
        wdata  = '0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_random();
`ifdef UCIE_CTL_TX_FIFO_AFULL_EN
        test_afull();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
